// File: rtl/tester_pkg.sv
// Shared types and field-position helpers for the tester datapath blocks.
// Stimulus word = {delay, vector}; result word = {seq, dut_out}.
package tester_pkg;

    typedef enum logic [1:0] {
        VS_IDLE    = 2'd0,
        VS_SETTLE  = 2'd1,
        VS_CAPTURE = 2'd2,
        VS_WRITE   = 2'd3
    } vseq_state_t;

    // The vector / dut_out field always sits at the bottom of its word.
    localparam int VEC_LSB = 0;

    function automatic int upper_lsb(input int vec_width);
        return vec_width;
    endfunction

    function automatic int upper_width(input int word_width, input int vec_width);
        return word_width - vec_width;
    endfunction

endpackage

// File: rtl/vector_sequencer.sv
// Moves one test vector at a time: stimulus FIFO -> DUT -> settle -> capture
// -> tagged result FIFO word. Four-state FSM with an inline settle counter.
module vector_sequencer
    import tester_pkg::*;
#(
    parameter int STF_WIDTH = 24,
    parameter int RTF_WIDTH = 24,
    parameter int VEC_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           abort,
    input  logic [STF_WIDTH-1:0]           sfifo_data,
    output logic                           sfifo_rdreq,
    input  logic                           sfifo_rdempty,
    output logic [VEC_WIDTH-1:0]           dut_in,
    input  logic [VEC_WIDTH-1:0]           dut_out,
    output logic [RTF_WIDTH-1:0]           rfifo_data,
    output logic                           rfifo_wrreq,
    input  logic                           rfifo_wrfull,
    output logic                           busy,
    output logic [RTF_WIDTH-VEC_WIDTH-1:0] seq,
    output logic [1:0]                     dbg_state
);

    localparam int DLY_W   = upper_width(STF_WIDTH, VEC_WIDTH);
    localparam int SEQ_W   = upper_width(RTF_WIDTH, VEC_WIDTH);
    localparam int DLY_LSB = upper_lsb(VEC_WIDTH);

    vseq_state_t            state_q, state_d;
    logic [VEC_WIDTH-1:0]   dut_in_q, dut_in_d;
    logic [DLY_W-1:0]       cnt_q, cnt_d;
    logic [RTF_WIDTH-1:0]   res_q, res_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;

    logic [VEC_WIDTH-1:0]   word_vec;
    logic [DLY_W-1:0]       word_dly;

    assign word_vec = sfifo_data[VEC_LSB +: VEC_WIDTH];
    assign word_dly = sfifo_data[DLY_LSB +: DLY_W];

    // Handshakes: sfifo_rdreq pops the show-ahead head in the same cycle it is
    // high (only when !sfifo_rdempty); rfifo_wrreq pushes rfifo_data in the
    // same cycle it is high (only when !rfifo_wrfull). Both are single-cycle.
    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        seq_d       = seq_q;
        sfifo_rdreq = 1'b0;
        rfifo_wrreq = 1'b0;

        if (abort) begin
            state_d = VS_IDLE;
        end else begin
            case (state_q)
                VS_IDLE: begin
                    if (enable && !sfifo_rdempty) begin
                        sfifo_rdreq = 1'b1;
                        dut_in_d    = word_vec;
                        cnt_d       = word_dly;
                        state_d     = VS_SETTLE;
                    end
                end
                VS_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end else begin
                        state_d = VS_CAPTURE;
                    end
                end
                VS_CAPTURE: begin
                    res_d   = {seq_q, dut_out};
                    state_d = VS_WRITE;
                end
                VS_WRITE: begin
                    // A full result FIFO stalls here; the result is never dropped.
                    if (!rfifo_wrfull) begin
                        rfifo_wrreq = 1'b1;
                        seq_d       = seq_q + SEQ_W'(1);
                        state_d     = VS_IDLE;
                    end
                end
                default: state_d = VS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= VS_IDLE;
            dut_in_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            seq_q    <= seq_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign rfifo_data = res_q;
    assign seq        = seq_q;
    assign busy       = (state_q != VS_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: emulated FIFOs, transaction-timestamp reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_vector_sequencer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        abort;
  logic [23:0] sfifo_data;
  logic        sfifo_rdreq;
  logic        sfifo_rdempty;
  logic [15:0] dut_in;
  logic [15:0] dut_out;
  logic [23:0] rfifo_data;
  logic        rfifo_wrreq;
  logic        rfifo_wrfull;
  logic        busy;
  logic [7:0]  seq;
  logic [1:0]  dbg_state;

  vector_sequencer #(.STF_WIDTH(24), .RTF_WIDTH(24), .VEC_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .abort(abort),
    .sfifo_data(sfifo_data), .sfifo_rdreq(sfifo_rdreq), .sfifo_rdempty(sfifo_rdempty),
    .dut_in(dut_in), .dut_out(dut_out),
    .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
    .busy(busy), .seq(seq), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // emulated FIFOs and scoreboard
  logic [23:0] stim_q[$];
  logic [23:0] exp_q[$];
  int          pop_log[$];
  logic [23:0] wr_log[$];

  // reference model: one vector in flight, described by its timestamps
  int          cyc;
  bit          in_flight;
  int          cap_cyc;
  int          wr_ok_cyc;
  logic [15:0] m_dut_in;
  logic [23:0] m_res;
  logic [7:0]  m_seq;
  bit          pop_flag;
  bit          loop_mode;
  logic [15:0] dut_out_val;

  int          n_checks;
  int          n_fail;
  int          n_pops;
  int          n_writes;
  int          last_pop_cyc;
  int          last_wr_cyc;
  logic [23:0] last_wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic refresh_sfifo();
    sfifo_rdempty = (stim_q.size() == 0);
    sfifo_data    = (stim_q.size() == 0) ? 24'h0 : stim_q[0];
  endtask

  // compare process: called once per cycle at the falling edge
  task automatic check_cycle();
    bit          exp_rd;
    bit          exp_wr;
    logic [23:0] w;
    int          d;
    exp_rd = !in_flight && enable && !sfifo_rdempty && !abort;
    exp_wr = in_flight && (cyc >= wr_ok_cyc) && !rfifo_wrfull && !abort;
    chk("rdreq", sfifo_rdreq, exp_rd);
    chk("wrreq", rfifo_wrreq, exp_wr);
    chk("busy", busy, in_flight);
    chk("dut_in", dut_in, m_dut_in);
    chk("seq", seq, m_seq);
    chk("rfifo_data", rfifo_data, m_res);
    if (exp_wr && rfifo_wrreq) begin
      if (exp_q.size() > 0) chk("scoreboard", rfifo_data, exp_q.pop_front());
      else timeout_fail("scoreboard_empty");
    end
    if (sfifo_rdreq) begin
      n_pops++;
      last_pop_cyc = cyc;
      pop_log.push_back(cyc);
    end
    if (rfifo_wrreq) begin
      n_writes++;
      last_wr_cyc  = cyc;
      last_wr_data = rfifo_data;
      wr_log.push_back(rfifo_data);
    end
    if (abort) begin
      in_flight = 1'b0;
      exp_q.delete();
    end else if (in_flight && cyc == cap_cyc) begin
      m_res = {m_seq, dut_out};
      exp_q.push_back(m_res);
    end
    if (exp_wr) begin
      m_seq     = m_seq + 8'd1;
      in_flight = 1'b0;
    end
    if (exp_rd) begin
      w         = sfifo_data;
      d         = int'(w[23:16]);
      m_dut_in  = w[15:0];
      in_flight = 1'b1;
      cap_cyc   = cyc + 2 + d;
      wr_ok_cyc = cyc + 3 + d;
    end
    pop_flag = sfifo_rdreq;
    cyc++;
  endtask

  // one clock: check at the falling edge, then update FIFO/DUT-side inputs
  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    if (pop_flag && stim_q.size() > 0) void'(stim_q.pop_front());
    refresh_sfifo();
    dut_out = loop_mode ? dut_in : dut_out_val;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [23:0] w);
    stim_q.push_back(w);
    refresh_sfifo();
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_writes < target && k < budget) begin
      tick();
      k++;
    end
    if (n_writes < target) timeout_fail(name);
  endtask

  task automatic model_reset();
    in_flight = 1'b0;
    m_dut_in  = '0;
    m_res     = '0;
    m_seq     = '0;
    exp_q.delete();
  endtask

  initial begin
    int b;
    int w0;
    int p0;
    logic [7:0] s0;

    n_checks = 0; n_fail = 0; n_pops = 0; n_writes = 0; cyc = 0;
    pop_flag = 0; loop_mode = 1; dut_out_val = '0;
    model_reset();
    reset_n = 1'b0; enable = 1'b0; abort = 1'b0; rfifo_wrfull = 1'b0; dut_out = '0;
    refresh_sfifo();

    #1;
    chk("reset_rdreq", sfifo_rdreq, 0);
    chk("reset_wrreq", rfifo_wrreq, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dut_in", dut_in, 16'h0);
    chk("reset_seq", seq, 8'h0);
    chk("reset_rfifo_data", rfifo_data, 24'h0);
    chk("reset_state", dbg_state, 2'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // T1: zero delay loopback
    loop_mode = 1;
    enable = 1'b1;
    push_word({8'd0, 16'hA5A5});
    wait_writes(1, 30, "t1_write");
    chk("t1_latency", last_wr_cyc - last_pop_cyc, 3);
    chk("t1_data", last_wr_data, 24'h00A5A5);
    tick();
    chk("t1_seq", seq, 8'd1);

    // T2: delay 5, dut_out moves to BEEF six cycles after the pop
    loop_mode = 0;
    dut_out_val = 16'h0000;
    dut_out = 16'h0000;
    push_word({8'd5, 16'h1234});
    tick();
    chk("t2_dut_in", dut_in, 16'h1234);
    ticks(5);
    dut_out_val = 16'hBEEF;
    dut_out = 16'hBEEF;
    wait_writes(2, 30, "t2_write");
    chk("t2_latency", last_wr_cyc - last_pop_cyc, 8);
    chk("t2_data", last_wr_data, 24'h01BEEF);

    // T3: three back-to-back zero-delay words
    loop_mode = 1;
    b = pop_log.size();
    w0 = wr_log.size();
    push_word({8'd0, 16'h0001});
    push_word({8'd0, 16'h0002});
    push_word({8'd0, 16'h0003});
    wait_writes(5, 60, "t3_write");
    tick();
    if (pop_log.size() >= b + 3 && wr_log.size() >= w0 + 3) begin
      chk("t3_gap1", pop_log[b+1] - pop_log[b], 4);
      chk("t3_gap2", pop_log[b+2] - pop_log[b+1], 4);
      chk("t3_res0", wr_log[w0], 24'h020001);
      chk("t3_res1", wr_log[w0+1], 24'h030002);
      chk("t3_res2", wr_log[w0+2], 24'h040003);
    end else timeout_fail("t3_logs");

    // T4: result FIFO full for ten WRITE cycles
    rfifo_wrfull = 1'b1;
    w0 = n_writes;
    p0 = n_pops;
    push_word({8'd0, 16'h0F0F});
    ticks(13);
    chk("t4_no_write", n_writes - w0, 0);
    chk("t4_held_data", rfifo_data, 24'h050F0F);
    chk("t4_busy", busy, 1);
    rfifo_wrfull = 1'b0;
    wait_writes(w0 + 1, 10, "t4_write");
    tick();
    chk("t4_one_write", n_writes - w0, 1);
    chk("t4_one_pop", n_pops - p0, 1);
    chk("t4_wdata", last_wr_data, 24'h050F0F);

    // T5: abort mid-SETTLE, next word proceeds
    w0 = n_writes;
    push_word({8'd20, 16'h7777});
    push_word({8'd1, 16'h1111});
    ticks(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_seq", seq, 8'd6);
    chk("t5_dut_in", dut_in, 16'h7777);
    wait_writes(w0 + 1, 30, "t5_write");
    chk("t5_data", last_wr_data, 24'h061111);

    // T6: randomized traffic
    loop_mode = 0;
    for (int i = 0; i < 40; i++) push_word({8'($urandom_range(0, 3)), 16'($urandom)});
    for (int i = 0; i < 500; i++) begin
      enable       = ($urandom_range(0, 9) < 8);
      abort        = ($urandom_range(0, 49) == 0);
      rfifo_wrfull = ($urandom_range(0, 3) == 0);
      dut_out_val  = 16'($urandom);
      if ($urandom_range(0, 19) == 0) push_word({8'($urandom_range(0, 3)), 16'($urandom)});
      tick();
    end
    enable = 1'b1; abort = 1'b0; rfifo_wrfull = 1'b0;
    b = 0;
    while ((stim_q.size() > 0 || in_flight) && b < 600) begin
      dut_out_val = 16'($urandom);
      tick();
      b++;
    end
    if (stim_q.size() > 0 || in_flight) timeout_fail("t6_drain");

    // T7: 256 vectors wrap seq back to its starting value
    loop_mode = 1;
    s0 = m_seq;
    w0 = n_writes;
    for (int i = 0; i < 256; i++) push_word({8'd0, 16'(i)});
    wait_writes(w0 + 256, 1300, "t7_write");
    tick();
    chk("t7_wrap", seq, s0);

    // T8: reset in the middle of SETTLE
    push_word({8'd10, 16'hCAFE});
    ticks(4);
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk("t8_rdreq", sfifo_rdreq, 0);
    chk("t8_wrreq", rfifo_wrreq, 0);
    chk("t8_busy", busy, 0);
    chk("t8_dut_in", dut_in, 16'h0);
    chk("t8_seq", seq, 8'h0);
    chk("t8_rfifo_data", rfifo_data, 24'h0);
    model_reset();
    ticks(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    w0 = n_writes;
    push_word({8'd0, 16'h1357});
    wait_writes(w0 + 1, 30, "t8_write");
    chk("t8_data", last_wr_data, 24'h001357);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
